// File: rtl/pre_add_mac_pkg.sv
// Package for the pipelined pre-add multiply-accumulate block.
// Holds the default operand, accumulator and sample-counter widths, and the
// per-stage control word that travels down the pipeline next to the data.
package pre_add_mac_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ACC_WIDTH = 40;
  localparam int DEF_CNT_WIDTH = 16;

  // One control word per pipeline stage: sample present, and sample restarts
  // the accumulation. clr is only ever set together with vld.
  typedef struct packed {
    logic vld;
    logic clr;
  } ctrl_t;

endpackage : pre_add_mac_pkg

// File: rtl/pre_add_mac_ctrl_pipe.sv
// Control pipeline for pipelined_pre_add_mac.
// Carries in_valid/acc_clear alongside the three datapath stages.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, empties the pipeline
//   in_valid   in   a sample enters stage 1 this cycle
//   acc_clear  in   that sample restarts the accumulation (ignored without in_valid)
//   ctrl_p2    out  control word aligned with the registered product (stage 2)
//   vld_p3     out  valid aligned with the accumulator register (stage 3)
module pre_add_mac_ctrl_pipe
  import pre_add_mac_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  logic  acc_clear,
  output ctrl_t ctrl_p2,
  output logic  vld_p3
);

  ctrl_t ctrl_p1_d, ctrl_p1_q;
  ctrl_t ctrl_p2_d, ctrl_p2_q;
  logic  vld_p3_d, vld_p3_q;

  always_comb begin
    // A clear without a sample is dropped here, so later stages never see it.
    ctrl_p1_d.vld = in_valid;
    ctrl_p1_d.clr = in_valid & acc_clear;
    ctrl_p2_d     = ctrl_p1_q;
    // The clear bit is consumed by the accumulator update in stage 3, so only
    // the valid bit needs a third register.
    vld_p3_d      = ctrl_p2_q.vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_p1_q <= '0;
      ctrl_p2_q <= '0;
      vld_p3_q  <= 1'b0;
    end else begin
      ctrl_p1_q <= ctrl_p1_d;
      ctrl_p2_q <= ctrl_p2_d;
      vld_p3_q  <= vld_p3_d;
    end
  end

  assign ctrl_p2 = ctrl_p2_q;
  assign vld_p3  = vld_p3_q;

endmodule : pre_add_mac_ctrl_pipe

// File: rtl/pipelined_pre_add_mac.sv
// Pipelined pre-add multiply-accumulate: acc = clear ? (a+b)*c : acc + (a+b)*c.
// Three register stages (pre-add, multiply, accumulate), one sample per cycle,
// no backpressure. A sample presented on edge N produces out_valid three edges
// later. count tracks samples since the last clear (saturating), overflow is a
// sticky flag set when an accumulate carries out of ACC_WIDTH bits.
//
// Build option: define PRE_ADD_MAC_SAT_EN to clamp the accumulator to all-ones
// on overflow; otherwise it wraps modulo 2^ACC_WIDTH. The flag works either way.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, clears all state
//   in_valid   in   a/b/c/acc_clear carry a sample
//   acc_clear  in   sample starts a new accumulation
//   a, b, c    in   WIDTH-bit unsigned operands
//   out_valid  out  out/count/overflow updated this cycle
//   out        out  accumulator, held between valid outputs
//   count      out  samples accumulated since last clear, held between outputs
//   overflow   out  sticky accumulator-overflow flag
module pipelined_pre_add_mac
  import pre_add_mac_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 acc_clear,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam int SUM_W  = WIDTH + 1;
  localparam int PROD_W = 2 * WIDTH + 1;

  // The full product must fit in the accumulator, otherwise a clear sample
  // could not load it losslessly.
  if (ACC_WIDTH < PROD_W) begin : g_bad_acc_width
    $error("pipelined_pre_add_mac: ACC_WIDTH must be at least 2*WIDTH+1");
  end

  ctrl_t ctrl_p2;
  logic  vld_p3;

  pre_add_mac_ctrl_pipe u_ctrl_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .acc_clear (acc_clear),
    .ctrl_p2   (ctrl_p2),
    .vld_p3    (vld_p3)
  );

  // Accumulator update with either clamp or wrap; s carries the extra bit.
  function automatic logic [ACC_WIDTH-1:0] acc_limit(input logic [ACC_WIDTH:0] s);
`ifdef PRE_ADD_MAC_SAT_EN
    return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
`else
    return s[ACC_WIDTH-1:0];
`endif
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] n);
    return (&n) ? n : n + CNT_WIDTH'(1);
  endfunction

  logic [SUM_W-1:0]     sum_p1_d, sum_p1_q;
  logic [WIDTH-1:0]     c_p1_d, c_p1_q;
  logic [PROD_W-1:0]    prod_p2_d, prod_p2_q;
  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 ovf_d, ovf_q;
  logic [ACC_WIDTH:0]   acc_sum;

  always_comb begin
    // Stage 1: pre-add, c delayed to stay aligned with the sum
    sum_p1_d  = SUM_W'(a) + SUM_W'(b);
    c_p1_d    = c;

    // Stage 2: multiply at full precision
    prod_p2_d = PROD_W'(sum_p1_q) * PROD_W'(c_p1_q);

    // Stage 3: accumulate; bubbles leave acc, count and overflow untouched
    acc_sum   = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod_p2_q);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    if (ctrl_p2.vld) begin
      if (ctrl_p2.clr) begin
        // The product always fits, so a clear sample never overflows.
        acc_d = ACC_WIDTH'(prod_p2_q);
        cnt_d = CNT_WIDTH'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_limit(acc_sum);
        cnt_d = cnt_inc(cnt_q);
        ovf_d = ovf_q | acc_sum[ACC_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1_q  <= '0;
      c_p1_q    <= '0;
      prod_p2_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sum_p1_q  <= sum_p1_d;
      c_p1_q    <= c_p1_d;
      prod_p2_q <= prod_p2_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = vld_p3;
  assign out       = acc_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;

endmodule : pipelined_pre_add_mac

// File: tb/tb_pipelined_pre_add_mac.sv
// Directed bench for pipelined_pre_add_mac. Two instances share the stimulus:
// dut_a (ACC_WIDTH=40, CNT_WIDTH=16) and dut_b (ACC_WIDTH=34, CNT_WIDTH=2, for
// accumulator overflow and count saturation). Inputs change on the falling
// edge; outputs are sampled on the falling edge, so a sample driven at one
// falling edge appears three falling edges later.
module tb_pipelined_pre_add_mac;

  localparam int W = 16;

`ifdef PRE_ADD_MAC_SAT_EN
  localparam logic [33:0] THIRD_B = 34'h3FFFFFFFF;
`else
  localparam logic [33:0] THIRD_B = 34'h1FFF40006;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, acc_clear;
  logic [W-1:0] a, b, c;

  logic         vld_a, ovf_a;
  logic [39:0]  out_a;
  logic [15:0]  cnt_a;
  logic         vld_b, ovf_b;
  logic [33:0]  out_b;
  logic [1:0]   cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipelined_pre_add_mac #(.WIDTH(W), .ACC_WIDTH(40), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .acc_clear(acc_clear),
    .a(a), .b(b), .c(c),
    .out_valid(vld_a), .out(out_a), .count(cnt_a), .overflow(ovf_a)
  );

  pipelined_pre_add_mac #(.WIDTH(W), .ACC_WIDTH(34), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .acc_clear(acc_clear),
    .a(a), .b(b), .c(c),
    .out_valid(vld_b), .out(out_b), .count(cnt_b), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic v, input logic clr,
                       input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [W-1:0] cc);
    in_valid  = v;
    acc_clear = clr;
    a = aa;
    b = bb;
    c = cc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, '0, '0, '0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_vld", 64'(vld_a), 64'd0);
    chk("rst_out", 64'(out_a), 64'd0);
    chk("rst_cnt", 64'(cnt_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);

    // Clear sample then follow-on sample: 35, then 35+20=55
    @(negedge clk); rst_n = 1'b1; drive(1'b1, 1'b1, 16'd3, 16'd4, 16'd5);
    @(negedge clk); chk("lat1_vld", 64'(vld_a), 64'd0); drive(1'b1, 1'b0, 16'd1, 16'd1, 16'd10);
    @(negedge clk); chk("lat2_vld", 64'(vld_a), 64'd0); drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("s1_vld", 64'(vld_a), 64'd1);
    chk("s1_out", 64'(out_a), 64'd35);
    chk("s1_cnt", 64'(cnt_a), 64'd1);
    chk("s1_ovf", 64'(ovf_a), 64'd0);
    @(negedge clk);
    chk("s2_vld", 64'(vld_a), 64'd1);
    chk("s2_out", 64'(out_a), 64'd55);
    chk("s2_cnt", 64'(cnt_a), 64'd2);
    @(negedge clk);
    chk("idle_vld", 64'(vld_a), 64'd0);
    chk("idle_out", 64'(out_a), 64'd55);

    // Valid, bubble, valid: +4 -> 59, hold, +3 -> 62
    @(negedge clk); drive(1'b1, 1'b0, 16'd2, 16'd2, 16'd1);
    @(negedge clk); drive(1'b0, 1'b0, 16'd9, 16'd9, 16'd9);
    @(negedge clk); drive(1'b1, 1'b0, 16'd0, 16'd1, 16'd3);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0);
    chk("vbv1_vld", 64'(vld_a), 64'd1);
    chk("vbv1_out", 64'(out_a), 64'd59);
    chk("vbv1_cnt", 64'(cnt_a), 64'd3);
    @(negedge clk);
    chk("vbv2_vld", 64'(vld_a), 64'd0);
    chk("vbv2_out", 64'(out_a), 64'd59);
    chk("vbv2_cnt", 64'(cnt_a), 64'd3);
    @(negedge clk);
    chk("vbv3_vld", 64'(vld_a), 64'd1);
    chk("vbv3_out", 64'(out_a), 64'd62);
    chk("vbv3_cnt", 64'(cnt_a), 64'd4);

    // acc_clear without in_valid is ignored; next sample adds 1 to 62
    @(negedge clk); drive(1'b0, 1'b1, 16'd7, 16'd7, 16'd7);
    @(negedge clk); drive(1'b1, 1'b0, 16'd1, 16'd0, 16'd1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("nclr_vld", 64'(vld_a), 64'd0);
    chk("nclr_out", 64'(out_a), 64'd62);
    chk("nclr_cnt", 64'(cnt_a), 64'd4);
    @(negedge clk);
    chk("nclr2_vld", 64'(vld_a), 64'd1);
    chk("nclr2_out", 64'(out_a), 64'd63);
    chk("nclr2_cnt", 64'(cnt_a), 64'd5);

    // Overflow on the 34-bit accumulator, count saturation at 3, then clear
    @(negedge clk); drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    @(negedge clk); drive(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    @(negedge clk); drive(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    chk("ov1_out", 64'(out_b), 64'h1FFFC0002);
    chk("ov1_ovf", 64'(ovf_b), 64'd0);
    chk("ov1_cnt", 64'(cnt_b), 64'd1);
    drive(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    chk("ov2_out", 64'(out_b), 64'h3FFF80004);
    chk("ov2_ovf", 64'(ovf_b), 64'd0);
    chk("ov2_cnt", 64'(cnt_b), 64'd2);
    drive(1'b1, 1'b1, 16'd3, 16'd4, 16'd5);
    @(negedge clk);
    chk("ov3_vld", 64'(vld_b), 64'd1);
    chk("ov3_out", 64'(out_b), 64'(THIRD_B));
    chk("ov3_ovf", 64'(ovf_b), 64'd1);
    chk("ov3_cnt", 64'(cnt_b), 64'd3);
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("sticky_out", 64'(out_b), 64'(THIRD_B));
    chk("sticky_ovf", 64'(ovf_b), 64'd1);
    chk("cnt_sat", 64'(cnt_b), 64'd3);
    @(negedge clk);
    chk("ovclr_out", 64'(out_b), 64'd35);
    chk("ovclr_ovf", 64'(ovf_b), 64'd0);
    chk("ovclr_cnt", 64'(cnt_b), 64'd1);

    // Asynchronous reset with two samples in flight
    @(negedge clk); drive(1'b1, 1'b1, 16'd1, 16'd1, 16'd1);
    @(negedge clk); drive(1'b1, 1'b0, 16'd1, 16'd1, 16'd1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(vld_a), 64'd0);
    chk("arst_out", 64'(out_a), 64'd0);
    chk("arst_cnt", 64'(cnt_a), 64'd0);
    chk("arst_ovf", 64'(ovf_b), 64'd0);
    chk("arst_outb", 64'(out_b), 64'd0);

    // Release; first sample accepted immediately, accumulation starts from 0
    @(negedge clk); rst_n = 1'b1; drive(1'b1, 1'b0, 16'd2, 16'd3, 16'd4);
    @(negedge clk); chk("rel1_vld", 64'(vld_a), 64'd0); drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk); chk("rel2_vld", 64'(vld_a), 64'd0);
    @(negedge clk);
    chk("rel3_vld", 64'(vld_a), 64'd1);
    chk("rel3_out", 64'(out_a), 64'd20);
    chk("rel3_cnt", 64'(cnt_a), 64'd1);
    @(negedge clk);
    chk("rel4_vld", 64'(vld_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pipelined_pre_add_mac
